// File: rtl/rst_seq_ctrl_pkg.sv
// Shared constants for the reset sequencer: register map, FSM encoding, STATUS bit layout.
package rst_seq_ctrl_pkg;

    localparam int unsigned ADDR_CTRL   = 32'h00;
    localparam int unsigned ADDR_WIDTH  = 32'h04;
    localparam int unsigned ADDR_GAP    = 32'h08;
    localparam int unsigned ADDR_STATUS = 32'h0C;
    localparam int unsigned ADDR_KICK   = 32'h10;

    localparam int STATUS_WDOG_BIT = 30;
    localparam int STATUS_BUSY_BIT = 31;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_HOLD    = 2'd1;
    localparam state_t ST_RELEASE = 2'd2;

    // Hold counter preload: counts down to 0, so W cycles need W-1; WIDTH=0 behaves as 1.
    function automatic logic [15:0] hold_load(input logic [15:0] width);
        return (width == 16'd0) ? 16'd0 : width - 16'd1;
    endfunction

endpackage

// File: rtl/rst_seq_release.sv
// Release scheduler: strips the lowest still-asserted channel every GAP+1 cycles,
// or every channel at once when GAP is zero.
module rst_seq_release #(
    parameter int C_CH_NUM = 4
) (
    input  logic                clk_i,
    input  logic                srst_i,
    input  logic                start_i,
    input  logic                active_i,
    input  logic [7:0]          gap_i,
    input  logic [C_CH_NUM-1:0] remain_i,
    output logic [C_CH_NUM-1:0] remain_d_o
);

    logic [7:0]          gap_cnt_q, gap_cnt_d;
    logic [C_CH_NUM-1:0] lowest;
    logic                found;
    logic                strip;

    always_comb begin
        lowest = '0;
        found  = 1'b0;
        for (int i = 0; i < C_CH_NUM; i++) begin
            if (!found && remain_i[i]) begin
                lowest[i] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    assign strip = start_i || (active_i && (gap_cnt_q == 8'd0));

    always_comb begin
        remain_d_o = remain_i;
        if (strip) begin
            remain_d_o = (gap_i == 8'd0) ? '0 : (remain_i & ~lowest);
        end
    end

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (start_i) begin
            gap_cnt_d = gap_i;
        end else if (active_i) begin
            gap_cnt_d = (gap_cnt_q == 8'd0) ? gap_i : gap_cnt_q - 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            gap_cnt_q <= 8'd0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset sequencer with register interface and staggered release.
// Optional watchdog auto-trigger is compiled in with `define RST_SEQ_CTRL_WDOG_EN.
module rst_seq_ctrl
    import rst_seq_ctrl_pkg::*;
#(
    parameter int C_CH_NUM         = 4,
    parameter int C_RST_CYCLES_DEF = 50,
    parameter int C_ADDR_W         = 16
`ifdef RST_SEQ_CTRL_WDOG_EN
    ,
    parameter int C_WDOG_CYCLES    = 1000000
`endif
) (
    input  logic                SYS_CLK_I,
    input  logic                SYS_RST_I,
    input  logic                WR_REQ_I,
    input  logic [C_ADDR_W-1:0] WR_ADDR_I,
    input  logic [31:0]         WR_DATA_I,
    input  logic                RD_REQ_I,
    input  logic [C_ADDR_W-1:0] RD_ADDR_I,
    output logic [31:0]         RD_DATA_O,
    output logic                RD_VLD_O,
    output logic [C_CH_NUM-1:0] RST_O,
    output logic [C_CH_NUM-1:0] RSTN_O,
    output logic                BUSY_O
);

    localparam logic [15:0] WIDTH_DEF = 16'(C_RST_CYCLES_DEF);

    state_t              state_q, state_d;
    logic [C_CH_NUM-1:0] rst_q, rst_d, rstn_q;
    logic [C_CH_NUM-1:0] active_q, active_d;
    logic [C_CH_NUM-1:0] trig_mask, rel_remain_d;
    logic [15:0]         hold_q, hold_d;
    logic [15:0]         width_q;
    logic [7:0]          gap_q, gap_lat_q, gap_lat_d;
    logic                rel_start, rel_active;
    logic                ctrl_wr, width_wr, gap_wr, status_rd;
    logic                wdog_fire, wdog_flag;
    logic [31:0]         status_w, rd_mux, rd_data_q;
    logic                rd_vld_q;
    logic                unused_wr_bits;

    assign ctrl_wr   = WR_REQ_I && (WR_ADDR_I == C_ADDR_W'(ADDR_CTRL));
    assign width_wr  = WR_REQ_I && (WR_ADDR_I == C_ADDR_W'(ADDR_WIDTH));
    assign gap_wr    = WR_REQ_I && (WR_ADDR_I == C_ADDR_W'(ADDR_GAP));
    assign status_rd = RD_REQ_I && (RD_ADDR_I == C_ADDR_W'(ADDR_STATUS));
    assign unused_wr_bits = ^WR_DATA_I[31:16];

`ifdef RST_SEQ_CTRL_WDOG_EN
    logic [31:0] wdog_cnt_q;
    logic        wdog_flag_q;
    logic        kick_wr;

    assign kick_wr   = WR_REQ_I && (WR_ADDR_I == C_ADDR_W'(ADDR_KICK));
    // Fires on the idle cycle in which the counter steps from 1 to 0.
    assign wdog_fire = (state_q == ST_IDLE) && (wdog_cnt_q == 32'd1) && !kick_wr;
    assign wdog_flag = wdog_flag_q;

    always_ff @(posedge SYS_CLK_I) begin
        if (SYS_RST_I) begin
            wdog_cnt_q  <= 32'(C_WDOG_CYCLES);
            wdog_flag_q <= 1'b0;
        end else begin
            if (kick_wr || (state_q != ST_IDLE)) begin
                wdog_cnt_q <= 32'(C_WDOG_CYCLES);
            end else if (wdog_cnt_q != 32'd0) begin
                wdog_cnt_q <= wdog_cnt_q - 32'd1;
            end
            if (wdog_fire) begin
                wdog_flag_q <= 1'b1;
            end else if (status_rd) begin
                wdog_flag_q <= 1'b0;
            end
        end
    end
`else
    assign wdog_fire = 1'b0;
    assign wdog_flag = 1'b0;
`endif

    always_comb begin
        trig_mask = '0;
        if (ctrl_wr) begin
            trig_mask = WR_DATA_I[C_CH_NUM-1:0];
        end
        if (wdog_fire) begin
            trig_mask = '1;
        end
    end

    always_comb begin
        state_d    = state_q;
        rst_d      = rst_q;
        active_d   = active_q;
        hold_d     = hold_q;
        gap_lat_d  = gap_lat_q;
        rel_start  = 1'b0;
        rel_active = 1'b0;
        if (trig_mask != '0) begin
            // A retrigger re-asserts the whole union, including already released channels.
            active_d  = ((state_q == ST_IDLE) ? '0 : active_q) | trig_mask;
            rst_d     = ((state_q == ST_IDLE) ? '0 : active_q) | trig_mask;
            hold_d    = hold_load(width_q);
            gap_lat_d = gap_q;
            state_d   = ST_HOLD;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (hold_q == 16'd0) begin
                        rel_start = 1'b1;
                        rst_d     = rel_remain_d;
                        state_d   = ST_RELEASE;
                    end else begin
                        hold_d = hold_q - 16'd1;
                    end
                end
                ST_RELEASE: begin
                    if (rst_q == '0) begin
                        active_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        rel_active = 1'b1;
                        rst_d      = rel_remain_d;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    rst_seq_release #(
        .C_CH_NUM (C_CH_NUM)
    ) u_release (
        .clk_i      (SYS_CLK_I),
        .srst_i     (SYS_RST_I),
        .start_i    (rel_start),
        .active_i   (rel_active),
        .gap_i      (gap_lat_q),
        .remain_i   (rst_q),
        .remain_d_o (rel_remain_d)
    );

    always_comb begin
        status_w                  = '0;
        status_w[C_CH_NUM-1:0]    = rst_q;
        status_w[STATUS_WDOG_BIT] = wdog_flag;
        status_w[STATUS_BUSY_BIT] = (state_q != ST_IDLE);
    end

    always_comb begin
        rd_mux = '0;
        case (RD_ADDR_I)
            C_ADDR_W'(ADDR_CTRL):   rd_mux[C_CH_NUM-1:0] = active_q;
            C_ADDR_W'(ADDR_WIDTH):  rd_mux[15:0] = width_q;
            C_ADDR_W'(ADDR_GAP):    rd_mux[7:0] = gap_q;
            C_ADDR_W'(ADDR_STATUS): rd_mux = status_w;
            C_ADDR_W'(ADDR_KICK):   rd_mux = '0;
            default:                rd_mux = '0;
        endcase
    end

    // Reset state doubles as the start of the power-up sequence.
    always_ff @(posedge SYS_CLK_I) begin
        if (SYS_RST_I) begin
            state_q   <= ST_HOLD;
            rst_q     <= '1;
            rstn_q    <= '0;
            active_q  <= '1;
            hold_q    <= hold_load(WIDTH_DEF);
            gap_lat_q <= 8'd0;
            width_q   <= WIDTH_DEF;
            gap_q     <= 8'd0;
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_q     <= rst_d;
            rstn_q    <= ~rst_d;
            active_q  <= active_d;
            hold_q    <= hold_d;
            gap_lat_q <= gap_lat_d;
            if (width_wr) begin
                width_q <= WR_DATA_I[15:0];
            end
            if (gap_wr) begin
                gap_q <= WR_DATA_I[7:0];
            end
            rd_vld_q  <= RD_REQ_I;
            rd_data_q <= RD_REQ_I ? rd_mux : 32'd0;
        end
    end

    assign RST_O     = rst_q;
    assign RSTN_O    = rstn_q;
    assign BUSY_O    = (state_q != ST_IDLE);
    assign RD_VLD_O  = rd_vld_q;
    assign RD_DATA_O = rd_data_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl; the watchdog section runs when RST_SEQ_CTRL_WDOG_EN is defined.
module tb_rst_seq_ctrl;

    logic        clk = 1'b0;
    logic        srst;
    logic        wr_req, rd_req;
    logic [15:0] wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_vld;
    logic [3:0]  rst_o, rstn_o;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rst_seq_ctrl #(
`ifdef RST_SEQ_CTRL_WDOG_EN
        .C_WDOG_CYCLES    (100),
`endif
        .C_CH_NUM         (4),
        .C_RST_CYCLES_DEF (50),
        .C_ADDR_W         (16)
    ) dut (
        .SYS_CLK_I (clk),
        .SYS_RST_I (srst),
        .WR_REQ_I  (wr_req),
        .WR_ADDR_I (wr_addr),
        .WR_DATA_I (wr_data),
        .RD_REQ_I  (rd_req),
        .RD_ADDR_I (rd_addr),
        .RD_DATA_O (rd_data),
        .RD_VLD_O  (rd_vld),
        .RST_O     (rst_o),
        .RSTN_O    (rstn_o),
        .BUSY_O    (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] addr, input logic [31:0] data);
        wr_req  = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_req  = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        rd_req  = 1'b1;
        rd_addr = addr;
        step();
        rd_req  = 1'b0;
        chk({tag, "_vld"}, {31'd0, rd_vld}, 32'd1);
        chk(tag, rd_data, exp);
        step();
        chk({tag, "_vld_low"}, {31'd0, rd_vld}, 32'd0);
        chk({tag, "_data_low"}, rd_data, 32'd0);
        $display("read 0x%02h -> 0x%08h", addr, exp);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic powerup(input string tag);
        for (int i = 0; i < 50; i++) begin
            chk({tag, "_hold"}, {28'd0, rst_o}, 32'hF);
            step();
        end
        chk({tag, "_rel"}, {28'd0, rst_o}, 32'h0);
        chk({tag, "_rel_busy"}, {31'd0, busy}, 32'd1);
        step();
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
        $display("%s: 50-cycle power-up sequence observed", tag);
    endtask

    initial begin
        logic [3:0] exp_rst;
        srst    = 1'b1;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        wr_addr = '0;
        rd_addr = '0;
        wr_data = '0;
        repeat (3) step();
        chk("reset_rst", {28'd0, rst_o}, 32'hF);
        chk("reset_rstn", {28'd0, rstn_o}, 32'h0);
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_rdvld", {31'd0, rd_vld}, 32'd0);
        chk("reset_rddata", rd_data, 32'd0);
        $display("reset state checked");

        srst = 1'b0;
        powerup("pwrup");
        rd_chk("width_def", 16'h04, 32'd50);
        rd_chk("gap_def", 16'h08, 32'd0);
        rd_chk("status_idle", 16'h0C, 32'd0);

        // Pulse on channels 0 and 2, WIDTH=10, GAP=0
        wr(16'h04, 32'd10);
        wr(16'h08, 32'd0);
        wr(16'h00, 32'h5);
        for (int t = 1; t <= 10; t++) begin
            chk("pulse_rst", {28'd0, rst_o}, 32'h5);
            chk("pulse_rstn", {28'd0, rstn_o}, 32'hA);
            step();
        end
        chk("pulse_end_rst", {28'd0, rst_o}, 32'h0);
        chk("pulse_end_rstn", {28'd0, rstn_o}, 32'hF);
        step();
        chk("pulse_idle", {31'd0, busy}, 32'd0);
        $display("pulse mask=0x5 width=10 gap=0 done");

        // Staggered release, WIDTH=4, GAP=2: channel k drops at N+5+3k
        wr(16'h04, 32'd4);
        wr(16'h08, 32'd2);
        wr(16'h00, 32'hF);
        for (int t = 1; t <= 15; t++) begin
            exp_rst = '0;
            for (int k = 0; k < 4; k++) begin
                if (t < 5 + 3 * k) exp_rst[k] = 1'b1;
            end
            chk("stagger_rst", {28'd0, rst_o}, {28'd0, exp_rst});
            chk("stagger_busy", {31'd0, busy}, {31'd0, (t < 15)});
            step();
        end
        $display("stagger mask=0xF width=4 gap=2 done");

        // Retrigger: mask 1 at N, mask 2 at N+3, WIDTH=8, GAP=0
        wr(16'h04, 32'd8);
        wr(16'h08, 32'd0);
        wr(16'h00, 32'h1);
        chk("retrig_n1", {28'd0, rst_o}, 32'h1);
        step();
        chk("retrig_n2", {28'd0, rst_o}, 32'h1);
        step();
        chk("retrig_n3", {28'd0, rst_o}, 32'h1);
        wr(16'h00, 32'h2);
        for (int t = 4; t <= 11; t++) begin
            chk("retrig_union", {28'd0, rst_o}, 32'h3);
            step();
        end
        chk("retrig_end", {28'd0, rst_o}, 32'h0);
        step();
        chk("retrig_idle", {31'd0, busy}, 32'd0);
        $display("retrigger 0x1 then 0x2 done");

        // WIDTH=0 acts as a single hold cycle
        wr(16'h04, 32'd0);
        wr(16'h00, 32'h8);
        chk("w0_hold", {28'd0, rst_o}, 32'h8);
        step();
        chk("w0_rel", {28'd0, rst_o}, 32'h0);
        chk("w0_rel_busy", {31'd0, busy}, 32'd1);
        step();
        chk("w0_idle", {31'd0, busy}, 32'd0);
        $display("width=0 single-cycle hold done");

        rd_chk("unmapped_1c", 16'h1C, 32'd0);

        wr(16'h00, 32'h0);
        chk("zero_mask_busy", {31'd0, busy}, 32'd0);
        chk("zero_mask_rst", {28'd0, rst_o}, 32'h0);
        $display("zero mask ignored");

        // WIDTH change while busy only affects the next trigger
        wr(16'h04, 32'd3);
        wr(16'h00, 32'h2);
        chk("wbusy_n1", {28'd0, rst_o}, 32'h2);
        wr(16'h04, 32'd10);
        chk("wbusy_n2", {28'd0, rst_o}, 32'h2);
        step();
        chk("wbusy_n3", {28'd0, rst_o}, 32'h2);
        step();
        chk("wbusy_n4", {28'd0, rst_o}, 32'h0);
        step();
        chk("wbusy_idle", {31'd0, busy}, 32'd0);
        rd_chk("wbusy_width", 16'h04, 32'd10);

        // STATUS read in the same cycle as a trigger sees the pre-write state
        wr_req  = 1'b1;
        wr_addr = 16'h00;
        wr_data = 32'h4;
        rd_req  = 1'b1;
        rd_addr = 16'h0C;
        step();
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        chk("status_pre_vld", {31'd0, rd_vld}, 32'd1);
        chk("status_pre_data", rd_data, 32'd0);
        chk("status_pre_rst", {28'd0, rst_o}, 32'h4);
        rd_chk("status_busy", 16'h0C, 32'h8000_0004);
        wait_idle("status_seq_end");
        $display("status read alongside trigger done");

`ifndef RST_SEQ_CTRL_WDOG_EN
        wr(16'h10, 32'h1);
        chk("kick_noop_busy", {31'd0, busy}, 32'd0);
        rd_chk("kick_noop_status", 16'h0C, 32'd0);
`endif

        // Reset asserted during HOLD overrides next cycle, then power-up repeats
        wr(16'h04, 32'd20);
        wr(16'h00, 32'h1);
        chk("midrst_hold", {28'd0, rst_o}, 32'h1);
        step();
        step();
        srst = 1'b1;
        step();
        chk("midrst_rst", {28'd0, rst_o}, 32'hF);
        chk("midrst_rstn", {28'd0, rstn_o}, 32'h0);
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        srst = 1'b0;
        powerup("pwrup2");
        rd_chk("width_after_rst", 16'h04, 32'd50);

`ifdef RST_SEQ_CTRL_WDOG_EN
        begin
            int n = 0;
            wr(16'h10, 32'h0);
            while (rst_o !== 4'hF && n < 300) begin
                step();
                n++;
            end
            chk("wdog_latency", n, 32'd100);
            rd_req  = 1'b1;
            rd_addr = 16'h0C;
            step();
            chk("wdog_flag_set", {31'd0, rd_data[30]}, 32'd1);
            step();
            rd_req  = 1'b0;
            chk("wdog_flag_clr", {31'd0, rd_data[30]}, 32'd0);
            wait_idle("wdog_seq_end");
            $display("watchdog fired after %0d idle cycles", n);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
